// File: rtl/store_aligner_if.sv
// Store request / bus beat channel between the memory stage and the data bus.
interface store_aligner_if #(
  parameter int unsigned BUS_BYTES = 8,
  parameter int unsigned ADDR_W    = 64
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [63:0]            in_data;
  logic [1:0]             in_msize;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_addr;
  logic [8*BUS_BYTES-1:0] out_data;
  logic [BUS_BYTES-1:0]   out_strobe;
  logic                   out_last;
  logic                   err;

  // Aligner side
  modport slave (
    input  in_valid, in_addr, in_data, in_msize, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_strobe, out_last, err
  );

  // Requester / bus side
  modport master (
    output in_valid, in_addr, in_data, in_msize, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_strobe, out_last, err
  );
endinterface

// File: rtl/store_aligner.sv
// Store-path aligner: places right-justified store data onto bus byte lanes,
// splitting bus-word-crossing stores into two beats or rejecting them.
module store_aligner #(
  parameter int unsigned BUS_BYTES        = 8,
  parameter int unsigned ADDR_W           = 64,
  parameter int unsigned SPLIT_MISALIGNED = 1
) (
  input logic             clk,
  input logic             reset,
  store_aligner_if.slave  bus
);
  localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
  localparam int unsigned DATA_W = 8 * BUS_BYTES;
  localparam int unsigned WIDE_W = 2 * DATA_W;
  localparam int unsigned WSTB_W = 2 * BUS_BYTES;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  state_t              state, state_nxt;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BUS_BYTES-1:0] strobe_q, strobe_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   hi_data_q, hi_data_d;
  logic [BUS_BYTES-1:0] hi_strobe_q, hi_strobe_d;

  logic                in_ready_c;
  logic                accept_c;
  logic [OFF_W-1:0]    off_c;
  logic [63:0]         size_data_c;
  logic [7:0]          size_bmask_c;
  logic [3:0]          n_bytes_c;
  logic                mis_c;
  logic                cross_c;
  logic [WIDE_W-1:0]   wide_data_c;
  logic [WSTB_W-1:0]   wide_strobe_c;
  logic [ADDR_W-1:0]   base_c;

  // Ready when idle, or when the final beat of the current request completes now
  assign in_ready_c = reset & ((state == IDLE) | (out_valid_q & bus.out_ready & last_q));
  assign accept_c   = bus.in_valid & in_ready_c;

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_data   = data_q;
  assign bus.out_strobe = strobe_q;
  assign bus.out_last   = last_q;
  assign bus.err        = err_q;

  // Per-request decode: size masking, alignment, lane placement over two bus words
  always_comb begin
    off_c        = bus.in_addr[OFF_W-1:0];
    size_data_c  = bus.in_data;
    size_bmask_c = 8'hFF;
    n_bytes_c    = 4'd8;
    mis_c        = |bus.in_addr[2:0];
    case (bus.in_msize)
      2'd0: begin
        size_data_c  = 64'(bus.in_data[7:0]);
        size_bmask_c = 8'h01;
        n_bytes_c    = 4'd1;
        mis_c        = 1'b0;
      end
      2'd1: begin
        size_data_c  = 64'(bus.in_data[15:0]);
        size_bmask_c = 8'h03;
        n_bytes_c    = 4'd2;
        mis_c        = bus.in_addr[0];
      end
      2'd2: begin
        size_data_c  = 64'(bus.in_data[31:0]);
        size_bmask_c = 8'h0F;
        n_bytes_c    = 4'd4;
        mis_c        = |bus.in_addr[1:0];
      end
      default: ;
    endcase
    cross_c       = ({1'b0, off_c} + (OFF_W+1)'(n_bytes_c)) > (OFF_W+1)'(BUS_BYTES);
    wide_data_c   = WIDE_W'(size_data_c) << {off_c, 3'b000};
    wide_strobe_c = WSTB_W'(size_bmask_c) << off_c;
    base_c        = {bus.in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  end

  // Next-state and beat register updates
  always_comb begin
    state_nxt   = state;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strobe_d    = strobe_q;
    last_d      = last_q;
    err_d       = 1'b0;
    hi_data_d   = hi_data_q;
    hi_strobe_d = hi_strobe_q;

    case (state)
      BEAT0: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_nxt   = IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_nxt = BEAT1;
            addr_d    = addr_q + ADDR_W'(BUS_BYTES);
            data_d    = hi_data_q;
            strobe_d  = hi_strobe_q;
            last_d    = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus.out_ready) begin
          state_nxt   = IDLE;
          out_valid_d = 1'b0;
        end
      end
      ERR:     state_nxt = IDLE;
      default: ;
    endcase

    // A new request overrides the completion above when accepted on the same edge
    if (accept_c) begin
      if (mis_c && (SPLIT_MISALIGNED == 0)) begin
        state_nxt   = ERR;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        err_d       = 1'b1;
      end else begin
        state_nxt   = BEAT0;
        out_valid_d = 1'b1;
        addr_d      = base_c;
        data_d      = wide_data_c[DATA_W-1:0];
        strobe_d    = wide_strobe_c[BUS_BYTES-1:0];
        hi_data_d   = wide_data_c[WIDE_W-1:DATA_W];
        hi_strobe_d = wide_strobe_c[WSTB_W-1:BUS_BYTES];
        last_d      = ~cross_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      strobe_q    <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      hi_data_q   <= '0;
      hi_strobe_q <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      last_q      <= last_d;
      err_q       <= err_d;
      hi_data_q   <= hi_data_d;
      hi_strobe_q <= hi_strobe_d;
    end
  end
endmodule

// File: tb/tb_store_aligner.sv
// Directed bench for store_aligner: 8-byte split, 8-byte reject and 16-byte split instances.
module tb_store_aligner;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  store_aligner_if #(.BUS_BYTES(8),  .ADDR_W(64)) b8  ();
  store_aligner_if #(.BUS_BYTES(8),  .ADDR_W(64)) b8e ();
  store_aligner_if #(.BUS_BYTES(16), .ADDR_W(64)) b16 ();

  store_aligner #(.BUS_BYTES(8),  .ADDR_W(64), .SPLIT_MISALIGNED(1)) u_s8  (.clk(clk), .reset(reset), .bus(b8));
  store_aligner #(.BUS_BYTES(8),  .ADDR_W(64), .SPLIT_MISALIGNED(0)) u_e8  (.clk(clk), .reset(reset), .bus(b8e));
  store_aligner #(.BUS_BYTES(16), .ADDR_W(64), .SPLIT_MISALIGNED(1)) u_s16 (.clk(clk), .reset(reset), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req8(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    b8.in_valid = 1'b1; b8.in_addr = a; b8.in_data = d; b8.in_msize = s;
  endtask

  task automatic req16(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    b16.in_valid = 1'b1; b16.in_addr = a; b16.in_data = d; b16.in_msize = s;
  endtask

  task automatic beat8(input string tag, input logic [63:0] a, input logic [7:0] st,
                       input logic [63:0] d, input logic l);
    chk({tag, "_valid"},  256'(b8.out_valid),  256'(1'b1));
    chk({tag, "_addr"},   256'(b8.out_addr),   256'(a));
    chk({tag, "_strobe"}, 256'(b8.out_strobe), 256'(st));
    chk({tag, "_data"},   256'(b8.out_data),   256'(d));
    chk({tag, "_last"},   256'(b8.out_last),   256'(l));
  endtask

  task automatic beat16(input string tag, input logic [63:0] a, input logic [15:0] st,
                        input logic [127:0] d, input logic l);
    chk({tag, "_valid"},  256'(b16.out_valid),  256'(1'b1));
    chk({tag, "_addr"},   256'(b16.out_addr),   256'(a));
    chk({tag, "_strobe"}, 256'(b16.out_strobe), 256'(st));
    chk({tag, "_data"},   256'(b16.out_data),   256'(d));
    chk({tag, "_last"},   256'(b16.out_last),   256'(l));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    b8.in_valid  = 1'b0; b8.in_addr  = '0; b8.in_data  = '0; b8.in_msize  = '0; b8.out_ready  = 1'b1;
    b8e.in_valid = 1'b0; b8e.in_addr = '0; b8e.in_data = '0; b8e.in_msize = '0; b8e.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_addr = '0; b16.in_data = '0; b16.in_msize = '0; b16.out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid",  256'(b8.out_valid),  256'(1'b0));
    chk("rst_err",    256'(b8e.err),       256'(1'b0));
    chk("rst_ready",  256'(b8.in_ready),   256'(1'b0));
    chk("rst_data",   256'(b16.out_data),  256'(0));
    chk("rst_strobe", 256'(b16.out_strobe), 256'(0));
    chk("rst_addr",   256'(b8.out_addr),   256'(0));
    chk("rst_last",   256'(b8.out_last),   256'(1'b0));
    reset = 1'b1;
    step();
    chk("post_rst_ready", 256'(b8.in_ready), 256'(1'b1));

    // 1: byte store, single beat
    req8(64'h1003, 64'hAB, 2'd0);
    step();
    b8.in_valid = 1'b0;
    beat8("s1", 64'h1000, 8'h08, 64'h00000000AB000000, 1'b1);
    chk("s1_in_ready", 256'(b8.in_ready), 256'(1'b1));
    step();
    chk("s1_done", 256'(b8.out_valid), 256'(1'b0));

    // 2: crossing word store, two beats
    req8(64'h1006, 64'h11223344, 2'd2);
    step();
    b8.in_valid = 1'b0;
    beat8("s2b0", 64'h1000, 8'hC0, 64'h3344000000000000, 1'b0);
    chk("s2b0_in_ready", 256'(b8.in_ready), 256'(1'b0));
    step();
    beat8("s2b1", 64'h1008, 8'h03, 64'h0000000000001122, 1'b1);
    chk("s2b1_in_ready", 256'(b8.in_ready), 256'(1'b1));
    step();
    chk("s2_done", 256'(b8.out_valid), 256'(1'b0));

    // 3: same store rejected when splitting is disabled
    b8e.in_valid = 1'b1; b8e.in_addr = 64'h1006; b8e.in_data = 64'h11223344; b8e.in_msize = 2'd2;
    step();
    b8e.in_valid = 1'b0;
    chk("s3_err",      256'(b8e.err),       256'(1'b1));
    chk("s3_valid",    256'(b8e.out_valid), 256'(1'b0));
    chk("s3_in_ready", 256'(b8e.in_ready),  256'(1'b0));
    step();
    chk("s3_err_clr",   256'(b8e.err),       256'(1'b0));
    chk("s3_valid2",    256'(b8e.out_valid), 256'(1'b0));
    chk("s3_in_ready2", 256'(b8e.in_ready),  256'(1'b1));

    // 4: scenario 2 with three stall cycles per beat, then a back-to-back byte store
    b8.out_ready = 1'b0;
    req8(64'h1006, 64'h11223344, 2'd2);
    step();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat8("s4b0", 64'h1000, 8'hC0, 64'h3344000000000000, 1'b0);
      chk("s4b0_in_ready", 256'(b8.in_ready), 256'(1'b0));
      if (i < 2) step();
    end
    b8.out_ready = 1'b1;
    #1;
    chk("s4b0_hs_in_ready", 256'(b8.in_ready), 256'(1'b0));
    step();
    b8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      beat8("s4b1", 64'h1008, 8'h03, 64'h0000000000001122, 1'b1);
      chk("s4b1_in_ready", 256'(b8.in_ready), 256'(1'b0));
      if (i < 2) step();
    end
    b8.out_ready = 1'b1;
    req8(64'h2001, 64'h5A, 2'd0);
    #1;
    chk("s4b1_hs_in_ready", 256'(b8.in_ready), 256'(1'b1));
    step();
    b8.in_valid = 1'b0;
    beat8("b2b", 64'h2000, 8'h02, 64'h0000000000005A00, 1'b1);
    step();
    chk("b2b_done", 256'(b8.out_valid), 256'(1'b0));

    // 5: 16-byte bus
    req16(64'h2008, 64'h0123456789ABCDEF, 2'd3);
    step();
    b16.in_valid = 1'b0;
    beat16("s5a", 64'h2000, 16'hFF00, 128'h0123456789ABCDEF_0000000000000000, 1'b1);
    step();
    chk("s5a_done", 256'(b16.out_valid), 256'(1'b0));
    req16(64'h2003, 64'hBEEF, 2'd1);
    step();
    b16.in_valid = 1'b0;
    beat16("s5b", 64'h2000, 16'h0018, 128'h000000BEEF000000, 1'b1);
    step();
    req16(64'hFFFF_FFFF_FFFF_FFFC, 64'h1122334455667788, 2'd3);
    step();
    b16.in_valid = 1'b0;
    beat16("s5c0", 64'hFFFF_FFFF_FFFF_FFF0, 16'hF000, 128'h55667788_000000000000000000000000, 1'b0);
    step();
    beat16("s5c1", 64'h0, 16'h000F, 128'h11223344, 1'b1);
    step();
    chk("s5c_done", 256'(b16.out_valid), 256'(1'b0));

    // 6: reset while in BEAT1, then a fresh store
    req8(64'h1006, 64'h11223344, 2'd2);
    step();
    b8.in_valid = 1'b0;
    step();
    beat8("s6b1", 64'h1008, 8'h03, 64'h0000000000001122, 1'b1);
    b8.out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("s6_rst_in_ready", 256'(b8.in_ready), 256'(1'b0));
    step();
    chk("s6_rst_valid", 256'(b8.out_valid), 256'(1'b0));
    chk("s6_rst_err",   256'(b8.err),       256'(1'b0));
    chk("s6_rst_last",  256'(b8.out_last),  256'(1'b0));
    reset = 1'b1;
    b8.out_ready = 1'b1;
    #1;
    chk("s6_in_ready", 256'(b8.in_ready), 256'(1'b1));
    req8(64'h3007, 64'hC3, 2'd0);
    step();
    b8.in_valid = 1'b0;
    beat8("s6new", 64'h3000, 8'h80, 64'hC300000000000000, 1'b1);
    step();
    chk("s6_done", 256'(b8.out_valid), 256'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- Store-path aligner between the memory stage and the data bus.
- Takes one store request (address, 64-bit right-justified data, size) and produces bus beats of BUS_BYTES width: byte-lane-shifted data plus a per-byte strobe.
- Generalises the combinational store-data lane placement to a parametrised bus width.
- Adds a sequential two-beat split for stores that cross a bus-word boundary, and a valid/ready handshake on both sides.

Parameters:
- BUS_BYTES, 8: bus width in bytes; power of two, 8..32.
- ADDR_W, 64: address width.
- SPLIT_MISALIGNED, 1: 1 = misaligned stores are executed, split into two beats if they cross a bus word; 0 = any misaligned store raises err and issues no beat.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  aligner can accept a request this cycle.
- in_addr  in  ADDR_W  byte address.
- in_data  in  64  store data, right-justified.
- in_msize  in  2  0=1B, 1=2B, 2=4B, 3=8B.
- out_valid  out  1  beat valid.
- out_ready  in  1  bus accepts beat.
- out_addr  out  ADDR_W  beat address; low log2(BUS_BYTES) bits are always 0.
- out_data  out  8*BUS_BYTES  lane-placed data; bytes not strobed are 0.
- out_strobe  out  BUS_BYTES  byte enables.
- out_last  out  1  final beat of the current request.
- err  out  1  one-cycle pulse: rejected misaligned store.

Behaviour:
- States: IDLE, BEAT0, BEAT1, ERR.
- Reset (reset=0 at a clock edge): state=IDLE, out_valid=0, out_last=0, err=0, out_data/out_strobe/out_addr=0.
  - in_ready=0 while reset is low.
  - A pending beat is dropped without completion.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back requests.
- Accept occurs on in_valid & in_ready; request fields are latched. Per-request arithmetic:
  - off = addr mod BUS_BYTES; n = 1<<msize.
  - mis = (addr mod n) != 0.
  - cross = off + n > BUS_BYTES.
  - Wide data = in_data[8n-1:0] << 8*off over 2*BUS_BYTES bytes.
  - Wide strobe = ((1<<n)-1) << off.
  - Low half is beat0, high half is beat1.
- Transitions on accept:
  - mis & SPLIT_MISALIGNED==0: go to ERR.
  - cross: go to BEAT0 with out_last=0.
  - Otherwise: go to BEAT0 with out_last=1.
- Latency: accept at edge t, beat0 (or err) visible from t+1. No combinational path from in_* to out_*.
- BEAT0:
  - out_addr = addr with low bits cleared.
  - On out_ready: if last, go to IDLE (or BEAT0/ERR for a new request accepted the same edge); else go to BEAT1.
- BEAT1:
  - out_addr = base + BUS_BYTES, wrapping mod 2^ADDR_W; out_last=1.
  - On out_ready: go to IDLE or to the next request.
- Backpressure: while out_valid & !out_ready, out_addr, out_data, out_strobe and out_last are held bit-stable.
- ERR: err=1 for exactly one cycle; out_valid=0; in_ready=0; then go to IDLE.
- Naturally aligned stores never cross, since n <= BUS_BYTES; cross can only occur when mis=1.
- A misaligned store that stays within one bus word, with SPLIT_MISALIGNED=1, is issued as a single beat.
- in_msize is always legal: all sizes are <= 8 <= BUS_BYTES.

Test Plan:
1. BUS_BYTES=8. Byte store, addr 0x1003, data 0xAB → one beat: out_addr 0x1000, strobe 0x08, out_data 0x00000000AB000000, out_last=1, at cycle t+1.
2. BUS_BYTES=8, SPLIT=1. Word store, addr 0x1006, data 0x11223344 → two beats:
   - beat0: addr 0x1000, strobe 0xC0, data 0x3344000000000000, last=0.
   - beat1: addr 0x1008, strobe 0x03, data 0x0000000000001122, last=1.
3. Same request as scenario 2 with SPLIT=0 → err=1 for one cycle at t+1; out_valid never asserted; in_ready back to 1 at t+2.
4. Scenario 2 with out_ready=0 for 3 cycles during each beat → outputs bit-stable during the stalls; beat order and values unchanged; in_ready=0 until the last handshake.
5. BUS_BYTES=16, SPLIT=1:
   - Doubleword store, addr 0x2008 → strobe 0xFF00, single beat.
   - Halfword store, addr 0x2003 (misaligned, not crossing) → single beat, strobe 0x0018.
   - Doubleword store, addr 0xFFFFFFFFFFFFFFFC → beat1 out_addr wraps to 0x0.
6. reset=0 asserted while waiting in BEAT1 → next cycle out_valid=0, err=0; after reset=1, in_ready=1 and a fresh byte store completes normally.
